// File: rtl/axistream_packetizer.sv
// Single-word-buffered AXI-Stream stage that frames an unframed stream with tlast.
// Optional idle timeout enabled by defining AXISTREAM_PACKETIZER_TIMEOUT_EN.
module axistream_packetizer #(
  parameter int DATA_WIDTH    = 8,
  parameter int LEN_WIDTH     = 16,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     src_tvalid,
  output logic                     src_tready,
  input  logic [DATA_WIDTH-1:0]    src_tdata,
  output logic                     dest_tvalid,
  input  logic                     dest_tready,
  output logic [DATA_WIDTH-1:0]    dest_tdata,
  output logic                     dest_tlast,
  input  logic                     add_tlast,
  input  logic [LEN_WIDTH-1:0]     pkt_len,
  output logic [LEN_WIDTH-1:0]     word_cnt,
  output logic                     pkt_done
`ifdef AXISTREAM_PACKETIZER_TIMEOUT_EN
  ,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles
`endif
);

  logic                  buf_valid;
  logic                  sealed;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  accept;
  logic                  xfer;
  logic                  last_xfer;
  logic                  timeout_hit;
  logic [LEN_WIDTH-1:0]  next_cnt;

  assign src_tready  = rst_n & (~buf_valid | dest_tready);
  // A word is held until its successor arrives or it is known to be last.
  assign dest_tvalid = buf_valid & (src_tvalid | sealed | add_tlast);
  assign dest_tlast  = dest_tvalid & (sealed | add_tlast);
  assign dest_tdata  = buf_data;

  assign accept    = src_tvalid & src_tready;
  assign xfer      = dest_tvalid & dest_tready;
  assign last_xfer = xfer & dest_tlast;

  always_comb begin
    next_cnt = word_cnt + LEN_WIDTH'(1);
    if (last_xfer) begin
      next_cnt = LEN_WIDTH'(1);
    end else if (word_cnt == '1) begin
      next_cnt = word_cnt;
    end
  end

`ifdef AXISTREAM_PACKETIZER_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] idle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (accept || xfer) begin
      idle_cnt <= '0;
    end else if (buf_valid && !sealed && !src_tvalid && idle_cnt != '1) begin
      idle_cnt <= idle_cnt + TIMEOUT_WIDTH'(1);
    end
  end

  assign timeout_hit = buf_valid & ~sealed & (timeout_cycles != '0) &
                       (idle_cnt >= timeout_cycles);
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      sealed    <= 1'b0;
      word_cnt  <= '0;
      pkt_done  <= 1'b0;
    end else begin
      pkt_done <= last_xfer;
      if (accept) begin
        buf_valid <= 1'b1;
        word_cnt  <= next_cnt;
        sealed    <= (pkt_len != '0) && (next_cnt >= pkt_len);
      end else if (xfer) begin
        buf_valid <= 1'b0;
        sealed    <= 1'b0;
        if (dest_tlast) begin
          word_cnt <= '0;
        end
      end else if (buf_valid && (add_tlast || timeout_hit)) begin
        sealed <= 1'b1;
      end
    end
  end

  // NOTE: the data register is qualified by buf_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_data <= src_tdata;
    end
  end

endmodule

// File: tb/tb_axistream_packetizer.sv
// Directed bench for axistream_packetizer: expected beats go into a scoreboard
// queue; a negedge monitor pops and compares every downstream transfer.
module tb_axistream_packetizer;

  localparam int DW = 8;
  localparam int LW = 16;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          src_tvalid;
  logic          src_tready;
  logic [DW-1:0] src_tdata;
  logic          dest_tvalid;
  logic          dest_tready;
  logic [DW-1:0] dest_tdata;
  logic          dest_tlast;
  logic          add_tlast;
  logic [LW-1:0] pkt_len;
  logic [LW-1:0] word_cnt;
  logic          pkt_done;
  logic [TW-1:0] timeout_cycles;

  int tests  = 0;
  int failed = 0;
  int done_seen = 0;
  int done_exp  = 0;
  logic [DW:0] exp_q[$];

  always #5 clk = ~clk;

  axistream_packetizer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .TIMEOUT_WIDTH(TW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .src_tvalid     (src_tvalid),
    .src_tready     (src_tready),
    .src_tdata      (src_tdata),
    .dest_tvalid    (dest_tvalid),
    .dest_tready    (dest_tready),
    .dest_tdata     (dest_tdata),
    .dest_tlast     (dest_tlast),
    .add_tlast      (add_tlast),
    .pkt_len        (pkt_len),
    .word_cnt       (word_cnt),
    .pkt_done       (pkt_done)
`ifdef AXISTREAM_PACKETIZER_TIMEOUT_EN
    ,
    .timeout_cycles (timeout_cycles)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input logic last);
    exp_q.push_back({last, d});
    if (last) done_exp++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every downstream transfer must match the next expected beat.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pkt_done) done_seen++;
      if (dest_tvalid && dest_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {23'd0, dest_tlast, dest_tdata}, 32'h1ff);
        end else begin
          check("beat", {23'd0, dest_tlast, dest_tdata}, {23'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    int  idx;
    logic acc;

    rst_n = 1'b0; src_tvalid = 1'b0; src_tdata = '0; dest_tready = 1'b1;
    add_tlast = 1'b0; pkt_len = '0; timeout_cycles = '0;
    #1;
    check("rst_src_tready", src_tready, 0);
    check("rst_dest_tvalid", dest_tvalid, 0);
    check("rst_dest_tlast", dest_tlast, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_pkt_done", pkt_done, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Test 1: pkt_len=4, continuous 0x01..0x08 -> tlast on 0x04 and 0x08.
    pkt_len = 16'd4;
    for (int i = 1; i <= 8; i++) push(DW'(i), (i % 4) == 0);
    for (int i = 1; i <= 8; i++) begin
      src_tvalid = 1'b1;
      src_tdata  = DW'(i);
      step();
      check("t1_word_cnt", word_cnt, ((i - 1) % 4) + 1);
    end
    src_tvalid = 1'b0;
    repeat (3) step();
    check("t1_word_cnt_end", word_cnt, 0);
    check("t1_pkt_done_count", done_seen, 2);

    // Test 2: unlimited length, close with add_tlast after idle.
    pkt_len = '0;
    push(8'hA0, 1'b0);
    push(8'hA1, 1'b1);
    src_tvalid = 1'b1; src_tdata = 8'hA0; step();
    src_tdata = 8'hA1; step();
    src_tvalid = 1'b0;
    repeat (3) step();
    check("t2_idle_tvalid", dest_tvalid, 0);
    check("t2_idle_word_cnt", word_cnt, 2);
    add_tlast = 1'b1;
    #1;
    check("t2_tvalid_same_cycle", dest_tvalid, 1);
    check("t2_tlast_same_cycle", dest_tlast, 1);
    check("t2_tdata", dest_tdata, 8'hA1);
    step();
    add_tlast = 1'b0;
    check("t2_word_cnt_end", word_cnt, 0);

    // Test 3: add_tlast while downstream stalls with 0x55 buffered.
    push(8'h55, 1'b1);
    push(8'h56, 1'b1);
    src_tvalid = 1'b1; src_tdata = 8'h55; step();
    src_tdata = 8'h56; dest_tready = 1'b0; add_tlast = 1'b1;
    step();
    add_tlast = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_stall_tvalid", dest_tvalid, 1);
      check("t3_stall_tlast", dest_tlast, 1);
      check("t3_stall_tdata", dest_tdata, 8'h55);
      check("t3_stall_src_tready", src_tready, 0);
      step();
    end
    dest_tready = 1'b1;
    step();
    check("t3_word_cnt_next", word_cnt, 1);
    src_tvalid = 1'b0; add_tlast = 1'b1;
    step();
    add_tlast = 1'b0;
    check("t3_word_cnt_end", word_cnt, 0);

    // Test 4: reset mid-packet with 0x33 buffered and word_cnt=2.
    push(8'h32, 1'b0);
    src_tvalid = 1'b1; src_tdata = 8'h32; step();
    src_tdata = 8'h33; step();
    src_tvalid = 1'b0;
    check("t4_word_cnt_pre", word_cnt, 2);
    rst_n = 1'b0;
    #1;
    check("t4_rst_tvalid", dest_tvalid, 0);
    check("t4_rst_src_tready", src_tready, 0);
    check("t4_rst_word_cnt", word_cnt, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    push(8'h40, 1'b1);
    src_tvalid = 1'b1; src_tdata = 8'h40; step();
    src_tvalid = 1'b0;
    #1;
    check("t4_word_cnt_new", word_cnt, 1);
    check("t4_no_stray_tvalid", dest_tvalid, 0);
    add_tlast = 1'b1;
    step();
    add_tlast = 1'b0;

    // Test 5: pkt_len=1, add_tlast held, dest_tready toggling.
    pkt_len = 16'd1;
    add_tlast = 1'b1;
    for (int i = 0; i < 8; i++) push(DW'(8'h10 + i), 1'b1);
    cyc = 0; idx = 0;
    while (idx < 8 && cyc < 100) begin
      src_tvalid  = 1'b1;
      src_tdata   = DW'(8'h10 + idx);
      dest_tready = cyc[0];
      #1;
      acc = src_tready;
      step();
      if (acc) idx++;
      cyc++;
    end
    check("t5_all_accepted", idx, 8);
    src_tvalid = 1'b0; dest_tready = 1'b1;
    repeat (3) step();
    add_tlast = 1'b0;
    check("t5_word_cnt_end", word_cnt, 0);

`ifdef AXISTREAM_PACKETIZER_TIMEOUT_EN
    // Test 6: idle timeout of 5 cycles closes a lone word.
    pkt_len = '0;
    timeout_cycles = 8'd5;
    push(8'h7E, 1'b1);
    src_tvalid = 1'b1; src_tdata = 8'h7E; step();
    src_tvalid = 1'b0;
    cyc = 0;
    while (!dest_tvalid && cyc < 20) begin
      step();
      cyc++;
    end
    check("t6_timeout_latency", cyc, 6);
    check("t6_timeout_tlast", dest_tlast, 1);
    repeat (2) step();
    timeout_cycles = '0;
`endif

    repeat (3) step();
    check("scoreboard_empty", exp_q.size(), 0);
    check("pkt_done_total", done_seen, done_exp);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
